// File: rtl/control_step_sequencer.sv
// Control-step sequencer for the Mini SRC control unit.
// One-hot T strobes with memory stretch, halt, restart and timeout fault.
module control_step_sequencer #(
  parameter int NUM_STEPS = 8,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         end_instr,
  input  logic                         mem_req,
  input  logic                         mfc,
  output logic [NUM_STEPS-1:0]         T,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         run,
  output logic                         mem_wait,
  output logic                         instr_done,
  output logic                         fault,
  output logic [CNT_W-1:0]             instr_count
);

  localparam int SW = $clog2(NUM_STEPS);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [NUM_STEPS-1:0] ONE = {{(NUM_STEPS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_HALTED,
    S_RUN,
    S_WAIT,
    S_FAULT
  } state_t;

  state_t               r_state;
  logic [NUM_STEPS-1:0] r_t;
  logic [SW-1:0]        r_step;
  logic                 r_run;
  logic                 r_mem_wait;
  logic                 r_done;
  logic                 r_fault;
  logic [CNT_W-1:0]     r_cnt;
  logic [WW-1:0]        r_wcnt;

  logic                 w_wrap;
  logic [SW-1:0]        w_next;
  logic [NUM_STEPS-1:0] w_next_t;

  // Last step is an implicit instruction end.
  always_comb begin
    w_wrap   = end_instr || (r_step == SW'(NUM_STEPS - 1));
    w_next   = w_wrap ? '0 : r_step + 1'b1;
    w_next_t = ONE << w_next;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_HALTED;
      r_t        <= '0;
      r_step     <= '0;
      r_run      <= 1'b0;
      r_mem_wait <= 1'b0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
      r_cnt      <= '0;
      r_wcnt     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_HALTED: begin
          if (start && !stop) begin
            r_state <= S_RUN;
            r_t     <= ONE;
            r_step  <= '0;
            r_run   <= 1'b1;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_HALTED;
            r_t     <= '0;
            r_step  <= '0;
            r_run   <= 1'b0;
          end else if (mem_req && !mfc) begin
            r_state    <= S_WAIT;
            r_mem_wait <= 1'b1;
            r_wcnt     <= WW'(1);
          end else begin
            r_t    <= w_next_t;
            r_step <= w_next;
            if (w_wrap) begin
              r_done <= 1'b1;
              r_cnt  <= r_cnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (stop) begin
            r_state    <= S_HALTED;
            r_t        <= '0;
            r_step     <= '0;
            r_run      <= 1'b0;
            r_mem_wait <= 1'b0;
            r_wcnt     <= '0;
          end else if (mfc) begin
            r_state    <= S_RUN;
            r_mem_wait <= 1'b0;
            r_wcnt     <= '0;
            r_t        <= w_next_t;
            r_step     <= w_next;
            if (w_wrap) begin
              r_done <= 1'b1;
              r_cnt  <= r_cnt + 1'b1;
            end
          end else if (r_wcnt == WW'(TIMEOUT)) begin
            r_state    <= S_FAULT;
            r_t        <= '0;
            r_step     <= '0;
            r_run      <= 1'b0;
            r_mem_wait <= 1'b0;
            r_fault    <= 1'b1;
            r_wcnt     <= '0;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_FAULT: begin
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  assign T           = r_t;
  assign step_idx    = r_step;
  assign run         = r_run;
  assign mem_wait    = r_mem_wait;
  assign instr_done  = r_done;
  assign fault       = r_fault;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_control_step_sequencer.sv
// Directed bench for control_step_sequencer: 8-step/timeout-4 instance
// plus a 3-step/2-bit-counter instance, scoreboard of expected snapshots.
module tb_control_step_sequencer;

  logic clk = 1'b0;
  logic clr, start, stop, end_instr, mem_req, mfc;

  logic [7:0]  a_t;
  logic [2:0]  a_idx;
  logic        a_run, a_mw, a_done, a_flt;
  logic [15:0] a_cnt;

  logic [2:0]  b_t;
  logic [1:0]  b_idx;
  logic        b_run, b_mw, b_done, b_flt;
  logic [1:0]  b_cnt;

  typedef struct packed {
    logic [7:0]  t;
    logic [2:0]  idx;
    logic        run, mw, done, flt;
    logic [15:0] cnt;
  } sa_t;

  typedef struct packed {
    logic [2:0] t;
    logic [1:0] idx;
    logic       run, mw, done, flt;
    logic [1:0] cnt;
  } sb_t;

  sa_t qa[$];
  sb_t qb[$];
  int  n_run  = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  control_step_sequencer #(
    .NUM_STEPS(8), .TIMEOUT(4), .CNT_W(16)
  ) u_a (
    .clk(clk), .clr(clr), .start(start), .stop(stop),
    .end_instr(end_instr), .mem_req(mem_req), .mfc(mfc),
    .T(a_t), .step_idx(a_idx), .run(a_run), .mem_wait(a_mw),
    .instr_done(a_done), .fault(a_flt), .instr_count(a_cnt)
  );

  control_step_sequencer #(
    .NUM_STEPS(3), .TIMEOUT(16), .CNT_W(2)
  ) u_b (
    .clk(clk), .clr(clr), .start(start), .stop(stop),
    .end_instr(end_instr), .mem_req(mem_req), .mfc(mfc),
    .T(b_t), .step_idx(b_idx), .run(b_run), .mem_wait(b_mw),
    .instr_done(b_done), .fault(b_flt), .instr_count(b_cnt)
  );

  function automatic sa_t ea(logic [7:0] t, logic [2:0] i, logic r,
                             logic w, logic d, logic f, logic [15:0] c);
    return {t, i, r, w, d, f, c};
  endfunction

  function automatic sb_t eb(logic [2:0] t, logic [1:0] i, logic r,
                             logic w, logic d, logic f, logic [1:0] c);
    return {t, i, r, w, d, f, c};
  endfunction

  // ctl = {clr, start, stop, end_instr, mem_req, mfc}
  task automatic step_a(input string tag, input logic [5:0] ctl,
                        input sa_t e);
    sa_t got, exp;
    {clr, start, stop, end_instr, mem_req, mfc} = ctl;
    qa.push_back(e);
    @(posedge clk);
    #1;
    got = {a_t, a_idx, a_run, a_mw, a_done, a_flt, a_cnt};
    exp = qa.pop_front();
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step_b(input string tag, input logic [5:0] ctl,
                        input sb_t e);
    sb_t got, exp;
    {clr, start, stop, end_instr, mem_req, mfc} = ctl;
    qb.push_back(e);
    @(posedge clk);
    #1;
    got = {b_t, b_idx, b_run, b_mw, b_done, b_flt, b_cnt};
    exp = qb.pop_front();
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    {clr, start, stop, end_instr, mem_req, mfc} = 6'b0;
    @(posedge clk);
    #1;

    // reset and full walk
    step_a("reset", 6'b100000, ea(8'h00, 0, 0, 0, 0, 0, 0));
    step_a("start", 6'b010000, ea(8'h01, 0, 1, 0, 0, 0, 0));
    for (int i = 1; i < 8; i++)
      step_a("walk", 6'b000000, ea(8'h01 << i, 3'(i), 1, 0, 0, 0, 0));
    step_a("wrap", 6'b000000, ea(8'h01, 0, 1, 0, 1, 0, 1));

    // early end in T5
    for (int i = 1; i < 6; i++)
      step_a("to_t5", 6'b000000, ea(8'h01 << i, 3'(i), 1, 0, 0, 0, 1));
    step_a("early_end", 6'b000100, ea(8'h01, 0, 1, 0, 1, 0, 2));

    // memory stretch in T1, mfc after three wait cycles
    step_a("t1", 6'b000000, ea(8'h02, 1, 1, 0, 0, 0, 2));
    step_a("wait1", 6'b000010, ea(8'h02, 1, 1, 1, 0, 0, 2));
    step_a("wait2", 6'b000010, ea(8'h02, 1, 1, 1, 0, 0, 2));
    step_a("wait3", 6'b000010, ea(8'h02, 1, 1, 1, 0, 0, 2));
    step_a("mfc", 6'b000011, ea(8'h04, 2, 1, 0, 0, 0, 2));
    step_a("req_mfc", 6'b000011, ea(8'h08, 3, 1, 0, 0, 0, 2));

    // stop during WAIT
    step_a("wait_t3", 6'b000010, ea(8'h08, 3, 1, 1, 0, 0, 2));
    step_a("stop_wait", 6'b001010, ea(8'h00, 0, 0, 0, 0, 0, 2));
    step_a("start_stop", 6'b011000, ea(8'h00, 0, 0, 0, 0, 0, 2));

    // stop beats end_instr in T3
    step_a("restart", 6'b010000, ea(8'h01, 0, 1, 0, 0, 0, 2));
    for (int i = 1; i < 4; i++)
      step_a("to_t3", 6'b000000, ea(8'h01 << i, 3'(i), 1, 0, 0, 0, 2));
    step_a("stop_end", 6'b001100, ea(8'h00, 0, 0, 0, 0, 0, 2));
    step_a("halt_idle", 6'b000100, ea(8'h00, 0, 0, 0, 0, 0, 2));

    // timeout in T2
    step_a("start2", 6'b010000, ea(8'h01, 0, 1, 0, 0, 0, 2));
    step_a("t1b", 6'b000000, ea(8'h02, 1, 1, 0, 0, 0, 2));
    step_a("t2b", 6'b000000, ea(8'h04, 2, 1, 0, 0, 0, 2));
    step_a("to_w1", 6'b000010, ea(8'h04, 2, 1, 1, 0, 0, 2));
    for (int i = 2; i <= 4; i++)
      step_a("to_wn", 6'b000000, ea(8'h04, 2, 1, 1, 0, 0, 2));
    step_a("fault", 6'b000000, ea(8'h00, 0, 0, 0, 0, 1, 2));
    step_a("flt_start", 6'b010000, ea(8'h00, 0, 0, 0, 0, 1, 2));
    step_a("flt_mfc", 6'b010011, ea(8'h00, 0, 0, 0, 0, 1, 2));
    step_a("flt_stop", 6'b001000, ea(8'h00, 0, 0, 0, 0, 1, 2));
    step_a("flt_clr", 6'b100000, ea(8'h00, 0, 0, 0, 0, 0, 0));

    // 3-step instance, 2-bit counter wrap
    step_b("b_reset", 6'b100000, eb(3'b000, 0, 0, 0, 0, 0, 0));
    step_b("b_start", 6'b010000, eb(3'b001, 0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      step_b("b_t1", 6'b000000, eb(3'b010, 1, 1, 0, 0, 0, 2'(k - 1)));
      step_b("b_t2", 6'b000000, eb(3'b100, 2, 1, 0, 0, 0, 2'(k - 1)));
      step_b("b_wrap", 6'b000000, eb(3'b001, 0, 1, 0, 1, 0, 2'(k)));
    end
    step_b("b_wait1", 6'b000010, eb(3'b001, 0, 1, 1, 0, 0, 1));
    step_b("b_wait2", 6'b000010, eb(3'b001, 0, 1, 1, 0, 0, 1));
    step_b("b_clr", 6'b100010, eb(3'b000, 0, 0, 0, 0, 0, 0));
    step_b("b_idle", 6'b000010, eb(3'b000, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
